// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86-style pipeline encodings and the hazard bundle passed from
// pipe_hazard to pipe_ctrl.
package pipe_ctrl_pkg;

    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd2;
    localparam logic [2:0] STAT_INS = 3'd3;
    localparam logic [2:0] STAT_HLT = 3'd4;

    typedef struct packed {
        logic lu;     // load/use
        logic mp;     // mispredicted jump
        logic rt;     // ret somewhere in D/E/M
        logic m_exc;
        logic w_exc;
    } hazard_t;

    function automatic logic is_exc(input logic [2:0] stat);
        return stat inside {STAT_ADR, STAT_INS, STAT_HLT};
    endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Purely combinational hazard detection: load/use, mispredict, ret in flight
// and exception status in the memory and write-back stages.
module pipe_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] d_icode,
    input  logic [3:0] d_src_a,
    input  logic [3:0] d_src_b,
    input  logic [3:0] e_icode,
    input  logic [3:0] e_dst_m,
    input  logic       e_cnd,
    input  logic [3:0] m_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] w_stat,
    output hazard_t    haz
);

    always_comb begin
        haz.lu    = (e_icode inside {IMRMOVQ, IPOPQ}) && (e_dst_m != RNONE) &&
                    ((e_dst_m == d_src_a) || (e_dst_m == d_src_b));
        haz.mp    = (e_icode == IJXX) && !e_cnd;
        haz.rt    = (d_icode == IRET) || (e_icode == IRET) || (m_icode == IRET);
        haz.m_exc = is_exc(m_stat);
        haz.w_exc = is_exc(w_stat);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: run/drain/halt FSM, stall and bubble steering for the
// five stages, and saturating stall/bubble event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic             cc_en_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t  state;
    hazard_t haz;

    pipe_hazard u_hazard (
        .d_icode (D_icode_i),
        .d_src_a (d_srcA_i),
        .d_src_b (d_srcB_i),
        .e_icode (E_icode_i),
        .e_dst_m (E_dstM_i),
        .e_cnd   (e_cnd_i),
        .m_icode (M_icode_i),
        .m_stat  (m_stat_i),
        .w_stat  (W_stat_i),
        .haz     (haz)
    );

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_stall_o  = 1'b0;
        cc_en_o    = 1'b0;
        if (rst_i) begin
            // Hold everything quiet while reset is asserted.
        end else if (state == HALTED) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            M_bubble_o = 1'b1;
            W_stall_o  = 1'b1;
        end else begin
            F_stall_o  = haz.lu | haz.rt;
            D_stall_o  = haz.lu;
            D_bubble_o = haz.mp | (haz.rt & ~haz.lu);
            E_bubble_o = haz.mp | haz.lu;
            M_bubble_o = haz.m_exc | haz.w_exc;
            W_stall_o  = haz.w_exc;
            // An excepting instruction must never update the condition codes.
            cc_en_o    = (state == RUN) & ~haz.m_exc & ~haz.w_exc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RUN;
            halted_o <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (haz.w_exc) begin
                        state    <= HALTED;
                        halted_o <= 1'b1;
                    end else if (haz.m_exc) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (haz.w_exc) begin
                        state    <= HALTED;
                        halted_o <= 1'b1;
                    end
                end
                HALTED: begin
                    state    <= HALTED;
                    halted_o <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    halted_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else if (state != HALTED) begin
            if (F_stall_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if ((D_bubble_o || E_bubble_o) && (bubble_cnt_o != '1))
                bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a behavioural model;
// a second instance with 4-bit counters exercises saturation.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] d_icode, d_src_a, d_src_b, e_icode, e_dst_m, m_icode;
    logic       e_cnd;
    logic [2:0] m_stat, w_stat;

    logic        f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, cc_en, halted;
    logic [31:0] stall_cnt, bubble_cnt;
    logic        s_f_stall, s_d_stall, s_d_bubble, s_e_bubble, s_m_bubble, s_w_stall, s_cc_en, s_halted;
    logic [3:0]  s_stall_cnt, s_bubble_cnt;

    pipe_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(d_icode), .d_srcA_i(d_src_a), .d_srcB_i(d_src_b),
        .E_icode_i(e_icode), .E_dstM_i(e_dst_m), .e_cnd_i(e_cnd),
        .M_icode_i(m_icode), .m_stat_i(m_stat), .W_stat_i(w_stat),
        .F_stall_o(f_stall), .D_stall_o(d_stall), .D_bubble_o(d_bubble),
        .E_bubble_o(e_bubble), .M_bubble_o(m_bubble), .W_stall_o(w_stall),
        .cc_en_o(cc_en), .halted_o(halted),
        .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut_small (
        .clk_i(clk), .rst_i(rst),
        .D_icode_i(d_icode), .d_srcA_i(d_src_a), .d_srcB_i(d_src_b),
        .E_icode_i(e_icode), .E_dstM_i(e_dst_m), .e_cnd_i(e_cnd),
        .M_icode_i(m_icode), .m_stat_i(m_stat), .W_stat_i(w_stat),
        .F_stall_o(s_f_stall), .D_stall_o(s_d_stall), .D_bubble_o(s_d_bubble),
        .E_bubble_o(s_e_bubble), .M_bubble_o(s_m_bubble), .W_stall_o(s_w_stall),
        .cc_en_o(s_cc_en), .halted_o(s_halted),
        .stall_cnt_o(s_stall_cnt), .bubble_cnt_o(s_bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: machine phase plus unbounded event counts.
    localparam int PH_RUN = 0, PH_DRAIN = 1, PH_HALT = 2;
    int      phase = PH_RUN;
    longint  n_stalls = 0;
    longint  n_bubbles = 0;

    typedef struct packed {
        bit fs, ds, db, eb, mb, ws, cc;
    } exp_t;

    function automatic bit exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit lu, mp, rt, me, we;
        e  = '0;
        lu = (e_icode == 4'h5 || e_icode == 4'hB) && e_dst_m != 4'hF &&
             (e_dst_m == d_src_a || e_dst_m == d_src_b);
        mp = (e_icode == 4'h7) && !e_cnd;
        rt = (d_icode == 4'h9) || (e_icode == 4'h9) || (m_icode == 4'h9);
        me = exc(m_stat);
        we = exc(w_stat);
        if (rst) return e;
        if (phase == PH_HALT) begin
            e.fs = 1; e.ds = 1; e.mb = 1; e.ws = 1;
            return e;
        end
        e.fs = lu || rt;
        e.ds = lu;
        // A mispredict always squashes decode; ret squashes it only when not already stalled.
        e.db = mp || (rt && !lu);
        e.eb = mp || lu;
        e.mb = me || we;
        e.ws = we;
        e.cc = (phase == PH_RUN) && !me && !we;
        return e;
    endfunction

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check_all();
        exp_t e;
        e = predict();
        check("F_stall",  f_stall,  e.fs);
        check("D_stall",  d_stall,  e.ds);
        check("D_bubble", d_bubble, e.db);
        check("E_bubble", e_bubble, e.eb);
        check("M_bubble", m_bubble, e.mb);
        check("W_stall",  w_stall,  e.ws);
        check("cc_en",    cc_en,    e.cc);
        check("halted",   halted,   (!rst && phase == PH_HALT));
        check("stall_cnt",  stall_cnt,  n_stalls);
        check("bubble_cnt", bubble_cnt, n_bubbles);
        check("small_ctrl", {s_f_stall, s_d_stall, s_d_bubble, s_e_bubble, s_m_bubble, s_w_stall, s_cc_en, s_halted},
              {e.fs, e.ds, e.db, e.eb, e.mb, e.ws, e.cc, (!rst && phase == PH_HALT)});
        check("small_stall_cnt",  s_stall_cnt,  sat4(n_stalls));
        check("small_bubble_cnt", s_bubble_cnt, sat4(n_bubbles));
    endtask

    task automatic advance();
        exp_t e;
        if (rst) return;
        e = predict();
        if (phase != PH_HALT) begin
            if (e.fs) n_stalls++;
            if (e.db || e.eb) n_bubbles++;
            if (exc(w_stat))                         phase = PH_HALT;
            else if (phase == PH_RUN && exc(m_stat)) phase = PH_DRAIN;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        advance();
        @(negedge clk);
    endtask

    task automatic idle();
        d_icode = 4'h1; d_src_a = 4'hF; d_src_b = 4'hF;
        e_icode = 4'h1; e_dst_m = 4'hF; e_cnd = 1'b1;
        m_icode = 4'h1; m_stat = STAT_AOK; w_stat = STAT_AOK;
    endtask

    // Asynchronous reset pulse placed between edges, checked while asserted.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        phase = PH_RUN; n_stalls = 0; n_bubbles = 0;
        check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] rand_icode();
        case ($urandom_range(0, 5))
            0:       return 4'h5;
            1:       return 4'h7;
            2:       return 4'h9;
            3:       return 4'hB;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    function automatic logic [2:0] rand_stat();
        return ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : STAT_AOK;
    endfunction

    initial begin
        int halt_wait;
        idle();
        @(negedge clk);
        do_reset();

        // Load/use on srcA, two cycles.
        e_icode = 4'h5; e_dst_m = 4'h3; d_src_a = 4'h3;
        step(); step();
        // Mispredicted jump.
        idle(); e_icode = 4'h7; e_cnd = 1'b0;
        step();
        // Ret walking through D, E, M, then clear.
        idle(); d_icode = 4'h9; step();
        idle(); e_icode = 4'h9; step();
        idle(); m_icode = 4'h9; step();
        idle(); step();
        // Ret plus load/use via popq.
        e_icode = 4'hB; e_dst_m = 4'h2; d_src_b = 4'h2; d_icode = 4'h9;
        step();

        // Halt through DRAIN, then 10 frozen cycles with hazards present.
        idle(); m_stat = STAT_HLT; step();
        idle(); w_stat = STAT_HLT; step();
        idle(); e_icode = 4'h5; e_dst_m = 4'h1; d_src_a = 4'h1; e_cnd = 1'b0;
        for (int i = 0; i < 10; i++) step();
        do_reset();

        // RUN directly to HALTED when both exceptions arrive together.
        idle(); m_stat = STAT_ADR; w_stat = STAT_INS; step();
        idle(); step(); step();
        do_reset();

        // Saturation of the 4-bit counters, then reset in the middle of HALTED.
        idle(); e_icode = 4'h5; e_dst_m = 4'h0; d_src_a = 4'h0;
        for (int i = 0; i < 20; i++) step();
        check("small_sat_hold", s_stall_cnt, 4'hF);
        idle(); w_stat = STAT_HLT; step();
        idle(); step(); step();
        do_reset();
        idle(); step();

        // Randomized traffic, with a reset some cycles after each halt.
        halt_wait = 0;
        for (int i = 0; i < 1500; i++) begin
            d_icode = rand_icode(); e_icode = rand_icode(); m_icode = rand_icode();
            d_src_a = rand_reg(); d_src_b = rand_reg(); e_dst_m = rand_reg();
            e_cnd   = 1'($urandom_range(0, 1));
            m_stat  = rand_stat(); w_stat = rand_stat();
            step();
            if (phase == PH_HALT) begin
                halt_wait++;
                if (halt_wait > int'($urandom_range(2, 12))) begin
                    do_reset();
                    halt_wait = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
